datamover_chunk_scheduler: RTL

Sequencer for the datamover streamer: accepts one copy job of `len_i` words from `src_addr_i` to `dst_addr_i`, splits it into chunks of at most `CHUNK_WORDS`, and drives the source (load) and sink (store) HCI engines chunk by chunk. For every chunk it programs both engines, issues their start strobes, and waits for both to complete. It raises a one-cycle `done_o` pulse after the last chunk. It sits between the register-file/control FSM and the streamer's `ctrl_i`/`flags_o` fields.

---
 rtl/datamover_chunk_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/datamover_chunk_scheduler.sv
// ---------------------------------------------------------------------------
// datamover_chunk_scheduler
//
// Splits one copy job (len_i words, src_addr_i -> dst_addr_i) into chunks of
// at most CHUNK_WORDS words and sequences the source (load) and sink (store)
// engines through them: program both, strobe both, wait for both dones, then
// advance. A one-cycle done_o pulse closes the job.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   clear_i                    synchronous soft clear (back to reset values)
//   start_i                    job start, sampled only while idle
//   src_addr_i, dst_addr_i     job byte base addresses
//   len_i                      job length in words
//   src_ready_i, snk_ready_i   engine can accept a request
//   src_done_i, snk_done_i     one-cycle engine chunk-complete pulses
//   src_req_start_o,
//   snk_req_start_o            one-cycle engine start strobes
//   src_base_o, snk_base_o     current chunk byte base addresses
//   chunk_len_o                current chunk length in words (both engines)
//   busy_o                     job in progress, through the done_o cycle
//   done_o                     one-cycle job-complete pulse
//   chunk_cnt_o                chunks completed in the current job
// ---------------------------------------------------------------------------
module datamover_chunk_scheduler #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int LEN_W       = 16,
    parameter int CHUNK_WORDS = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    src_addr_i,
    input  logic [AW-1:0]    dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             src_ready_i,
    input  logic             snk_ready_i,
    input  logic             src_done_i,
    input  logic             snk_done_i,
    output logic             src_req_start_o,
    output logic             snk_req_start_o,
    output logic [AW-1:0]    src_base_o,
    output logic [AW-1:0]    snk_base_o,
    output logic [LEN_W-1:0] chunk_len_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] chunk_cnt_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

    localparam logic [LEN_W-1:0] CHUNK_MAX  = LEN_W'(CHUNK_WORDS);
    localparam logic [AW-1:0]    WORD_BYTES = AW'(DW / 8);

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             src_issued, snk_issued;
    logic             src_fin, snk_fin;

    logic             src_issued_now, snk_issued_now;
    logic             src_fin_now, snk_fin_now;
    logic             track_done;
    logic [LEN_W-1:0] rem_next;
    logic [AW-1:0]    stride;

    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] n);
        return (n > CHUNK_MAX) ? CHUNK_MAX : n;
    endfunction

    // Strobes are combinational so an engine that is ready in the first ISSUE
    // cycle is started without an extra cycle; the issued flag guarantees a
    // single strobe per chunk.
    assign src_req_start_o = (state == ISSUE) && !src_issued && src_ready_i;
    assign snk_req_start_o = (state == ISSUE) && !snk_issued && snk_ready_i;

    assign src_issued_now = src_issued | src_req_start_o;
    assign snk_issued_now = snk_issued | snk_req_start_o;

    // A done only counts once that engine's strobe is already registered;
    // pulses before issue or outside ISSUE/WAIT are stale and dropped.
    assign track_done  = (state == ISSUE) || (state == WAIT);
    assign src_fin_now = src_fin | (src_done_i & src_issued & track_done);
    assign snk_fin_now = snk_fin | (snk_done_i & snk_issued & track_done);

    assign rem_next = rem - chunk_len_o;
    assign stride   = AW'(chunk_len_o) * WORD_BYTES;  // wraps modulo 2^AW

    // NOTE: every register here is assigned with <= so all state updates of a
    // cycle see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            src_base_o  <= '0;
            snk_base_o  <= '0;
            chunk_len_o <= '0;
            chunk_cnt_o <= '0;
            rem         <= '0;
            src_issued  <= 1'b0;
            snk_issued  <= 1'b0;
            src_fin     <= 1'b0;
            snk_fin     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (clear_i) begin
            // NOTE: the soft clear repeats the reset branch rather than
            // sharing it, keeping the async reset term alone in the first
            // condition as flop inference expects.
            state       <= IDLE;
            src_base_o  <= '0;
            snk_base_o  <= '0;
            chunk_len_o <= '0;
            chunk_cnt_o <= '0;
            rem         <= '0;
            src_issued  <= 1'b0;
            snk_issued  <= 1'b0;
            src_fin     <= 1'b0;
            snk_fin     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // busy_o drops in the cycle after the done_o cycle.
                    busy_o <= start_i;
                    if (start_i) begin
                        src_base_o  <= src_addr_i;
                        snk_base_o  <= dst_addr_i;
                        rem         <= len_i;
                        chunk_len_o <= clip_len(len_i);
                        chunk_cnt_o <= '0;
                        state       <= (len_i != '0) ? ISSUE : FINISH;
                    end
                end
                ISSUE: begin
                    src_issued <= src_issued_now;
                    snk_issued <= snk_issued_now;
                    src_fin    <= src_fin_now;
                    snk_fin    <= snk_fin_now;
                    if (src_issued_now && snk_issued_now) state <= WAIT;
                end
                WAIT: begin
                    src_fin <= src_fin_now;
                    snk_fin <= snk_fin_now;
                    if (src_fin_now && snk_fin_now) state <= NEXT;
                end
                NEXT: begin
                    src_base_o  <= src_base_o + stride;
                    snk_base_o  <= snk_base_o + stride;
                    rem         <= rem_next;
                    chunk_cnt_o <= chunk_cnt_o + 1'b1;
                    src_issued  <= 1'b0;
                    snk_issued  <= 1'b0;
                    src_fin     <= 1'b0;
                    snk_fin     <= 1'b0;
                    if (rem_next == '0) begin
                        state <= FINISH;
                    end else begin
                        chunk_len_o <= clip_len(rem_next);
                        state       <= ISSUE;
                    end
                end
                FINISH: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
